muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with the HI/LO register pair, in the EX stage directly downstream of the register file.

---
 rtl/mips_muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 54 +++++
 rtl/muldiv_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// mips_muldiv_pkg
//   Shared definitions for the multiply/divide unit: op-code values as seen
//   on the op port, and the FSM state encoding.
//   Optional feature macro used by the unit: MULDIV_FAST_MUL_EN.
// ---------------------------------------------------------------------------
package mips_muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    // MULT and DIV treat their operands as two's-complement.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
//   One combinational iteration of the multiply/divide engine, operating on
//   the {acc, q} register pair.
//     multiply : LSB-first shift-add; m is the multiplicand, q holds the
//                multiplier and fills with product bits from the top.
//     divide   : restoring shift-subtract; m is the divisor, q holds the
//                dividend and fills with quotient bits from the bottom.
// Ports
//   is_div   in   1      select divide step (else multiply step)
//   acc_in   in   WIDTH  partial product high half / partial remainder
//   q_in     in   WIDTH  multiplier / dividend-quotient shift register
//   m        in   WIDTH  multiplicand / divisor magnitude
//   acc_out  out  WIDTH  updated accumulator
//   q_out    out  WIDTH  updated shift register
// ---------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, keeping the carry so the right shift loses nothing.
        sum = {1'b0, acc_in} + (q_in[0] ? {1'b0, m} : '0);

        // Divide: the shifted remainder can be one bit wider than the
        // divisor, so the trial compare is done at WIDTH+1 bits. When it
        // fits, the difference is below m and is exact in WIDTH bits.
        rem_sh = {acc_in, q_in[WIDTH-1]};
        fits   = (rem_sh >= {1'b0, m});
        diff   = rem_sh[WIDTH-1:0] - m;

        if (is_div) begin
            acc_out = fits ? diff : rem_sh[WIDTH-1:0];
            q_out   = {q_in[WIDTH-2:0], fits};
        end else begin
            acc_out = sum[WIDTH:1];
            q_out   = {sum[0], q_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit with the HI/LO register pair (EX stage).
//   MULT/MULTU/DIV/DIVU run iteratively (one step per cycle, WIDTH steps plus
//   a sign fix-up cycle); MTHI/MTLO complete in one cycle. While an iterative
//   op is in flight, busy is high and a stall is requested whenever the EX
//   instruction wants the unit (start) or its result (rd_hilo).
//   Optional feature macro: MULDIV_FAST_MUL_EN -- multiplies use a single-
//   cycle combinational multiplier; only divides go through the iterative
//   path.
// Ports
//   clk      in   1      clock, rising edge
//   reset    in   1      asynchronous active-low reset
//   start    in   1      op valid this cycle
//   op       in   3      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6-7 no-op
//   opa      in   WIDTH  rs (dividend / multiplicand / MTHI-MTLO source)
//   opb      in   WIDTH  rt (divisor / multiplier)
//   rd_hilo  in   1      EX instruction is MFHI/MFLO
//   flush    in   1      abort in-flight op
//   busy     out  1      iterative op in flight
//   stall    out  1      busy & (start | rd_hilo)
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
// ---------------------------------------------------------------------------
module muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             rd_hilo,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_reg, q_reg, m_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             is_div_reg, neg_q_reg, neg_r_reg, div0_reg;

    // FSM strobes
    logic accept, step_en, fix_en, mt_hi, mt_lo, fast_mul;
    logic iter_op;

    // operand conditioning
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // step and fix-up results
    logic [WIDTH-1:0]   step_acc, step_q;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        a_neg = is_signed_op(op) & opa[WIDTH-1];
        b_neg = is_signed_op(op) & opb[WIDTH-1];
        // -(-2^(W-1)) wraps to 2^(W-1), which is the correct magnitude
        // when read as unsigned.
        a_mag = a_neg ? (~opa + 1'b1) : opa;
        b_mag = b_neg ? (~opb + 1'b1) : opb;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;

    assign iter_op   = (op == OP_DIV) || (op == OP_DIVU);
    assign fast_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    assign fast_prod = (a_neg ^ b_neg) ? (~fast_mag + 1'b1) : fast_mag;
`else
    assign iter_op   = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and strobes. flush overrides everything, including a
    // same-cycle start and a pending FIXUP write.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step_en    = 1'b0;
        fix_en     = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        fast_mul   = 1'b0;

        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (iter_op) begin
                            accept     = 1'b1;
                            state_next = ST_CALC;
                        end else if (op == OP_MTHI) begin
                            mt_hi = 1'b1;
                        end else if (op == OP_MTLO) begin
                            mt_lo = 1'b1;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if ((op == OP_MULT) || (op == OP_MULTU)) begin
                            fast_mul = 1'b1;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    step_en = 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_next = ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    fix_en     = 1'b1;
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_reg),
        .acc_in  (acc_reg),
        .q_in    (q_reg),
        .m       (m_reg),
        .acc_out (step_acc),
        .q_out   (step_q)
    );

    // Sign fix-up applied on the magnitude result.
    always_comb begin
        prod_raw = {acc_reg, q_reg};
        prod_fix = neg_q_reg ? (~prod_raw + 1'b1) : prod_raw;
        // Divide by zero leaves the dividend magnitude in acc, so the
        // remainder fix-up already restores opa; only the quotient is forced.
        quo_fix  = div0_reg  ? '1 : (neg_q_reg ? (~q_reg + 1'b1) : q_reg);
        rem_fix  = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;
    end

    // -----------------------------------------------------------------------
    // Datapath and HI/LO registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            m_reg      <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            if (accept) begin
                cnt_reg    <= '0;
                acc_reg    <= '0;
                // op[1] distinguishes DIV/DIVU from MULT/MULTU
                is_div_reg <= op[1];
                div0_reg   <= op[1] & (opb == '0);
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= a_neg;
                if (op[1]) begin
                    q_reg <= a_mag;
                    m_reg <= b_mag;
                end else begin
                    q_reg <= b_mag;
                    m_reg <= a_mag;
                end
            end

            if (step_en) begin
                acc_reg <= step_acc;
                q_reg   <= step_q;
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (fix_en) begin
                if (is_div_reg) begin
                    hi_reg <= rem_fix;
                    lo_reg <= quo_fix;
                end else begin
                    {hi_reg, lo_reg} <= prod_fix;
                end
            end

            if (mt_hi) begin
                hi_reg <= opa;
            end
            if (mt_lo) begin
                lo_reg <= opa;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (fast_mul) begin
                {hi_reg, lo_reg} <= fast_prod;
            end
`endif
        end
    end

    assign busy  = (state_reg != ST_IDLE);
    assign stall = busy & (start | rd_hilo);
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed vectors with hand-computed HI/LO results, busy-cycle counts,
//   stall behaviour, flush and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYC = 0;
`else
    localparam int MUL_CYC = 33;
`endif
    localparam int DIV_CYC = 33;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] opa = '0;
    logic [WIDTH-1:0] opb = '0;
    logic             rd_hilo = 1'b0;
    logic             flush = 1'b0;
    logic             busy, stall;
    logic [WIDTH-1:0] hi, lo;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .opa     (opa),
        .opb     (opb),
        .rd_hilo (rd_hilo),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Count clock edges until busy drops, bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Launch one op, wait for completion, check busy length and HI/LO.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int exp_cyc,
                          input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(cyc);
        check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int cyc;
        int bad;

        // reset state
        #12;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // main function
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_CYC, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("multu_small", 3'd1, 32'h1234_5678, 32'h0000_0010, MUL_CYC, 32'h0000_0001, 32'h2345_6780);
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, MUL_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, DIV_CYC, 32'd2, 32'd14);
        run_op("divu_by0", 3'd3, 32'd100, 32'd0, DIV_CYC, 32'd100, 32'hFFFF_FFFF);
        run_op("div_by0_neg", 3'd2, 32'hFFFF_FF9C, 32'd0, DIV_CYC, 32'hFFFF_FF9C, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYC, 32'h0, 32'h8000_0000);

        // rd_hilo and start while busy
        @(negedge clk);
        start = 1'b1; op = 3'd3; opa = 32'd1000; opb = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rd_hilo = 1'b1;
        #1;
        check("stall_rd", 64'(stall), 64'h1);
        start = 1'b1; op = 3'd4; opa = 32'hDEAD;
        #1;
        check("stall_start", 64'(stall), 64'h1);
        @(posedge clk);
        #1;
        check("busy_hold", 64'(busy), 64'h1);
        start = 1'b0;
        bad = 0;
        cyc = 0;
        while (busy && cyc < 100) begin
            if (!stall) bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stall_until_idle", 64'(bad), 64'h0);
        check("busy_fell", 64'(busy), 64'h0);
        check("stall_idle_rd", 64'(stall), 64'h0);
        check("busy_div_hi", 64'(hi), 64'd1);
        check("busy_div_lo", 64'(lo), 64'd333);
        rd_hilo = 1'b0;

        // MTHI then MTLO
        @(negedge clk);
        start = 1'b1; op = 3'd4; opa = 32'h1234;
        #1;
        check("mthi_stall", 64'(stall), 64'h0);
        @(posedge clk);
        #1;
        check("mthi_busy", 64'(busy), 64'h0);
        check("mthi_hi", 64'(hi), 64'h1234);
        op = 3'd5; opa = 32'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mtlo_busy", 64'(busy), 64'h0);
        check("mtlo_hi", 64'(hi), 64'h1234);
        check("mtlo_lo", 64'(lo), 64'h5678);

        // reserved op
        @(negedge clk);
        start = 1'b1; op = 3'd6; opa = 32'hAAAA; opb = 32'h1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("rsv_busy", 64'(busy), 64'h0);
        check("rsv_hilo", {32'(hi), 32'(lo)}, {32'h1234, 32'h5678});

        // flush mid-CALC
        @(negedge clk);
        start = 1'b1; op = 3'd3; opa = 32'd50; opb = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("flush_pre_busy", 64'(busy), 64'h1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'h0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_hilo", {32'(hi), 32'(lo)}, {32'h1234, 32'h5678});

        // flush beats start
        @(negedge clk);
        start = 1'b1; op = 3'd3; opa = 32'd9; opb = 32'd2; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_win_busy", 64'(busy), 64'h0);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 3'd3; opa = 32'd12345; opb = 32'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'h0);
        check("rst_mid_hilo", {32'(hi), 32'(lo)}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_after", {32'(busy), 32'(hi | lo)}, 64'h0);

        // unit still works after reset
        run_op("post_rst_divu", 3'd3, 32'd12345, 32'd11, DIV_CYC, 32'd3, 32'd1122);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
